down_counter8_timer: RTL and testbench
======================================

Name: down_counter8_timer

Overview:
- Loadable 8-bit down counter: the decrementing counterpart of the team's 8-bit up counter, used as a programmable interval timer.
- Counts from a loaded value down to zero on prescaled enable ticks.
- Raises a sticky Expired flag at terminal count and optionally auto-reloads.
- Sits beside the up counter on the same Clock/Reset domain and feeds control logic that acknowledges expiry.

Parameters:
- WIDTH, 8, counter and data width in bits.
- PRESCALE, 1, enabled clocks per decrement tick (1 = every enabled clock); legal range 1..256.

Ports:
- Clock, input, 1, single rising-edge clock.
- Reset, input, 1, asynchronous active-low reset (asserted when 0).
- Enable, input, 1, advances the prescaler/counter while high in RUN.
- Load, input, 1, synchronous load of Data into Count and the reload register.
- Data, input, WIDTH, load value.
- Reload, input, 1, auto-reload mode select, sampled at each terminal tick.
- Ack, input, 1, clears the Expired flag.
- Count, output, WIDTH, current count, registered.
- Zero, output, 1, high when Count == 0 (combinational from the Count register).
- Expired, output, 1, sticky terminal-count flag, registered.
- Busy, output, 1, high when state == RUN.

Behaviour:
- Reset (Reset == 0, asynchronous), all values held until Reset == 1:
  - Count = 0, reload register = 0, prescaler = 0.
  - Expired = 0, state = IDLE, hence Busy = 0 and Zero = 1.
- States: IDLE, RUN, DONE.
- Priority per clock: Load > terminal tick > Enable hold.
- Load, any state:
  - Count <= Data, reload register <= Data, prescaler <= 0.
  - Next state is RUN if Data != 0, otherwise IDLE.
  - Expired is not set by a load.
- Tick definition: in RUN with Enable == 1, the prescaler increments; a tick occurs when the prescaler == PRESCALE-1, then the prescaler wraps to 0. With PRESCALE = 1, every enabled RUN clock is a tick.
- Enable == 0 in RUN: Count and prescaler hold and no tick occurs; Busy stays 1.
- Normal tick with Count > 1: Count <= Count - 1.
- Terminal tick (Count == 1):
  - Expired <= 1.
  - If Reload == 1: Count <= reload register and state stays RUN. The period is exactly reload-value ticks and no cycle sits at 0.
  - If Reload == 0: Count <= 0 and state <= DONE.
- DONE: Count holds 0; Enable is ignored. Ack == 1 moves to IDLE. Load restarts as described above.
- IDLE: Count holds; Enable is ignored; only Load leaves IDLE.
- Expired flag:
  - Set by a terminal tick, cleared by Ack.
  - Set and Ack in the same cycle: set wins, Expired stays 1.
  - Ack with Expired == 0 has no effect outside DONE.
- Load + Ack in the same cycle: the state follows Load and the Ack clears Expired.
- Load + terminal tick in the same cycle: Load wins and Expired is not set.
- Latency: every output changes on the clock edge following the causing input. Zero follows Count in the same cycle.
- Arithmetic: unsigned. Count never wraps below 0 (decrement only at Count ≥ 1) and never exceeds 2^WIDTH-1.
- Reset asserted mid-count: immediate return to reset values; the reload register is lost.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - default WIDTH and PRESCALE.
- One natural sub-module: down_counter8_prescaler, which holds the prescaler count and emits a one-cycle tick.
- The FSM, Count, reload register and Expired flag stay in the top module.

Test Plan:
- Reset then idle: Reset = 0 for 3 clocks, then 1 → Count = 0, Zero = 1, Expired = 0, Busy = 0. Enable = 1 for 10 clocks leaves everything unchanged.
- One-shot, PRESCALE = 1: Load Data = 5, Reload = 0, Enable = 1.
  - Count goes 5, 4, 3, 2, 1, 0 on successive clocks.
  - Expired = 1 and state DONE on the clock Count reaches 0; Busy = 0.
  - Ack → Expired = 0, state IDLE.
- Auto-reload: Load 3, Reload = 1, Enable = 1 for 10 clocks.
  - Count sequence 3, 2, 1, 3, 2, 1, 3, …
  - Expired goes 1 at the first wrap and stays 1.
  - Ack on the same clock as the second terminal tick leaves Expired = 1.
- Prescaler and hold, PRESCALE = 4: Load 2 with Enable high.
  - Count decrements every 4th clock.
  - Dropping Enable for 5 clocks mid-interval freezes Count and prescaler; resuming completes the remaining prescaler counts before the next decrement.
- Priority:
  - Load 9 on the same clock as a terminal tick → Count = 9, Expired stays 0, Busy = 1.
  - Load Data = 0 → Count = 0, state IDLE, Zero = 1, Expired unchanged.
- Async reset mid-operation: Load 200, run 50 ticks, assert Reset between clock edges → Count = 0 and Busy = 0 immediately, with no Expired pulse.

Source files
------------

// File: rtl/down_counter8_timer_pkg.sv
// Shared definitions for the down_counter8_timer block.
//   state_e          : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH    : default counter/data width in bits
//   DEFAULT_PRESCALE : default enabled clocks per decrement tick
package down_counter8_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/down_counter8_prescaler.sv
// Prescaler for the down counter timer: counts enabled clocks and emits a
// one-cycle tick on every PRESCALE-th one.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous restart of the prescale phase (takes priority)
//   advance : count this clock toward the next tick
//   tick    : high for the clock on which the phase reaches PRESCALE-1
module down_counter8_prescaler
  import down_counter8_timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic tick
);

  // One bit minimum so PRESCALE = 1 still has a legal (always zero) phase.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] phase_q, phase_d;

  assign tick = advance && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (advance) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/down_counter8_timer.sv
// Loadable down counter used as a programmable interval timer.
// Counts a loaded value down to zero on prescaled ticks, raises a sticky
// Expired flag at terminal count, and can auto-reload the loaded value.
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-low reset
//   Enable  : advances prescaler/counter while running
//   Load    : synchronous load of Data into Count and the reload register
//   Data    : load value
//   Reload  : auto-reload select, sampled at each terminal tick
//   Ack     : clears Expired (and returns DONE to IDLE)
//   Count   : current count (registered)
//   Zero    : Count == 0
//   Expired : sticky terminal-count flag (registered)
//   Busy    : high while running
module down_counter8_timer
  import down_counter8_timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  input  logic             Reload,
  input  logic             Ack,
  output logic [WIDTH-1:0] Count,
  output logic             Zero,
  output logic             Expired,
  output logic             Busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] reload_q,  reload_d;
  logic             expired_q, expired_d;
  logic             advance;
  logic             tick;

  // A load restarts the interval, so it must not also advance the prescaler.
  assign advance = (state_q == ST_RUN) && Enable && !Load;

  down_counter8_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (Load),
    .advance (advance),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = expired_q;

    // Ack clears first so that a terminal tick in the same cycle wins.
    if (Ack) begin
      expired_d = 1'b0;
    end

    if (Load) begin
      count_d  = Data;
      reload_d = Data;
      state_d  = (Data != '0) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (count_q == ONE) begin
              expired_d = 1'b1;
              if (Reload) begin
                // Jump straight to the reload value: no cycle spent at 0.
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end else if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (Ack) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          // Unused encoding: recover to a quiet state.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign Count   = count_q;
  assign Zero    = (count_q == '0);
  assign Expired = expired_q;
  assign Busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter8_timer.sv
module tb_down_counter8_timer;

  typedef struct packed {
    logic [7:0] cnt;
    logic       zero;
    logic       exp;
    logic       busy;
  } obs_t;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data = 8'd0;
  logic       rel = 1'b0;
  logic       ack = 1'b0;

  logic [7:0] count_a, count_b;
  logic       zero_a, zero_b, exp_a, exp_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per DUT instance.
  int ps       [2] = '{1, 4};
  int m_count  [2];
  int m_reload [2];
  int m_phase  [2];
  int m_mode   [2];
  int m_exp    [2];

  obs_t q0[$];
  obs_t q1[$];

  always #5 clk = ~clk;

  down_counter8_timer #(.WIDTH(8), .PRESCALE(1)) u_dut_p1 (
    .Clock(clk), .Reset(rst_n), .Enable(en), .Load(load), .Data(data),
    .Reload(rel), .Ack(ack), .Count(count_a), .Zero(zero_a),
    .Expired(exp_a), .Busy(busy_a)
  );

  down_counter8_timer #(.WIDTH(8), .PRESCALE(4)) u_dut_p4 (
    .Clock(clk), .Reset(rst_n), .Enable(en), .Load(load), .Data(data),
    .Reload(rel), .Ack(ack), .Count(count_b), .Zero(zero_b),
    .Expired(exp_b), .Busy(busy_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_reload[i] = 0; m_phase[i] = 0;
      m_mode[i] = M_IDLE; m_exp[i] = 0;
    end
  endtask

  // Behavioural timer: phase counts enabled clocks since the last tick.
  task automatic model_step(input int i, input bit ld, input int d,
                            input bit e, input bit r, input bit a);
    if (a) m_exp[i] = 0;
    if (ld) begin
      m_count[i]  = d;
      m_reload[i] = d;
      m_phase[i]  = 0;
      m_mode[i]   = (d != 0) ? M_RUN : M_IDLE;
    end else if (m_mode[i] == M_RUN && e) begin
      m_phase[i] = m_phase[i] + 1;
      if (m_phase[i] == ps[i]) begin
        m_phase[i] = 0;
        if (m_count[i] == 1) begin
          m_exp[i] = 1;
          if (r) m_count[i] = m_reload[i];
          else begin
            m_count[i] = 0;
            m_mode[i]  = M_DONE;
          end
        end else begin
          m_count[i] = m_count[i] - 1;
        end
      end
    end else if (m_mode[i] == M_DONE && a) begin
      m_mode[i] = M_IDLE;
    end
  endtask

  task automatic push_expect();
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      o.cnt  = 8'(m_count[i]);
      o.zero = (m_count[i] == 0);
      o.exp  = (m_exp[i] != 0);
      o.busy = (m_mode[i] == M_RUN);
      if (i == 0) q0.push_back(o);
      else        q1.push_back(o);
    end
  endtask

  task automatic drive(input bit ld, input int d, input bit e, input bit r, input bit a);
    @(negedge clk);
    rst_n = 1'b1;
    load  = ld;
    data  = 8'(d);
    en    = e;
    rel   = r;
    ack   = a;
    for (int i = 0; i < 2; i++) model_step(i, ld, d, e, r, a);
    push_expect();
  endtask

  // Asserts reset between clock edges and checks the asynchronous effect.
  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    ack   = 1'b0;
    model_reset();
    #1;
    chk("rst_now_cnt_p1",  count_a, 0);
    chk("rst_now_busy_p1", busy_a,  0);
    chk("rst_now_exp_p1",  exp_a,   0);
    chk("rst_now_zero_p1", zero_a,  1);
    chk("rst_now_cnt_p4",  count_b, 0);
    chk("rst_now_busy_p4", busy_b,  0);
    chk("rst_now_exp_p4",  exp_b,   0);
    push_expect();
    repeat (n - 1) begin
      @(negedge clk);
      push_expect();
    end
  endtask

  // Monitor: one observation per clock edge, compared against the scoreboard.
  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        o = q0.pop_front();
        chk("cnt_p1",  count_a, o.cnt);
        chk("zero_p1", zero_a,  o.zero);
        chk("exp_p1",  exp_a,   o.exp);
        chk("busy_p1", busy_a,  o.busy);
      end
      if (q1.size() > 0) begin
        o = q1.pop_front();
        chk("cnt_p4",  count_b, o.cnt);
        chk("zero_p4", zero_b,  o.zero);
        chk("exp_p4",  exp_b,   o.exp);
        chk("busy_p4", busy_b,  o.busy);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, e, r, a;
    int d;
    model_reset();

    // Reset, then Enable while idle must change nothing.
    do_reset(3);
    repeat (10) drive(0, 0, 1, 0, 0);

    // One-shot from 5, then acknowledge.
    drive(1, 5, 1, 0, 0);
    repeat (8) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1);

    // Auto-reload from 3; Ack coincides with the second terminal tick.
    for (int k = 0; k < 10; k++) drive(k == 0, 3, 1, 1, k == 6);

    // Prescaled count with an Enable gap mid-interval (Load + Ack together).
    drive(1, 2, 1, 0, 1);
    repeat (2) drive(0, 0, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 1, 0, 0);

    // Priority: Load on the terminal tick, then Load of zero.
    drive(0, 0, 0, 0, 1);
    drive(1, 2, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 9, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Randomized traffic, biased toward short intervals.
    for (int n = 0; n < 400; n++) begin
      ld = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 6));
      e  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 1) != 0;
      a  = ($urandom_range(0, 7) == 0);
      drive(ld, d, e, r, a);
    end

    // Asynchronous reset in the middle of a long count.
    drive(1, 200, 1, 0, 1);
    repeat (50) drive(0, 0, 1, 0, 0);
    do_reset(2);
    repeat (3) drive(0, 0, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("drain_p1", q0.size(), 0);
    chk("drain_p4", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
